// File: rtl/vga_framebuffer_scanner.sv
// Free-running 640x480 VGA scanner: walks the timing counters, fetches one byte per SxS block from
// RAM port B and expands RRRGGGBB to 4-bit RGB with sync, active and frame_start kept aligned.
module vga_framebuffer_scanner #(
  parameter int unsigned PIXEL_DIV   = 2,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned SCALE_SHIFT = 3,
  parameter logic [15:0] FB_BASE     = 16'h0200,
  parameter bit          SYNC_POL    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  color_data,
  output logic [15:0] color_address,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned DW      = $clog2(PIXEL_DIV);

  localparam logic [DW-1:0] DIV_LAST    = DW'(PIXEL_DIV - 1);
  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END   = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_VIS_END   = VW'(V_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_SYNC_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0]   ROW_BYTES   = 16'(H_ACTIVE >> SCALE_SHIFT);

  logic [DW-1:0] pix_div;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  logic        pix_en;
  logic        visible;
  logic        h_sync_on;
  logic        v_sync_on;
  logic [15:0] block_row;
  logic [15:0] block_col;
  logic [15:0] fetch_addr;

  always_comb begin
    pix_en     = (pix_div == DIV_LAST);
    visible    = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    h_sync_on  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    v_sync_on  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    block_row  = 16'(v_cnt >> SCALE_SHIFT);
    block_col  = 16'(h_cnt >> SCALE_SHIFT);
    // Constant multiply; the sum deliberately wraps at 16 bits.
    fetch_addr = FB_BASE + block_row * ROW_BYTES + block_col;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_div       <= '0;
      h_cnt         <= '0;
      v_cnt         <= '0;
      color_address <= FB_BASE;
      red           <= '0;
      green         <= '0;
      blue          <= '0;
      hsync         <= ~SYNC_POL;
      vsync         <= ~SYNC_POL;
      active        <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      pix_div       <= pix_en ? '0 : pix_div + 1'b1;
      color_address <= visible ? fetch_addr : FB_BASE;
      frame_start   <= pix_en && (h_cnt == '0) && (v_cnt == '0);

      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end

        // Output stage captures the pixel that was current for the period just ending.
        hsync  <= h_sync_on ? SYNC_POL : ~SYNC_POL;
        vsync  <= v_sync_on ? SYNC_POL : ~SYNC_POL;
        active <= visible;
        if (visible) begin
          red   <= {color_data[7:5], color_data[7]};
          green <= {color_data[4:2], color_data[4]};
          blue  <= {color_data[1:0], color_data[1:0]};
        end else begin
          red   <= '0;
          green <= '0;
          blue  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_framebuffer_scanner.sv
// Scoreboard bench: directed expectations keyed by clock index after reset release are queued by
// the stimulus process and popped/compared by a negedge monitor. Vertical timing is shortened.
module tb_vga_framebuffer_scanner;

  localparam int KRed = 0, KGrn = 1, KBlu = 2, KHs = 3, KVs = 4, KAct = 5, KFs = 6, KAddr = 7;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  color_data;
  logic [15:0] color_address;
  logic [3:0]  red, green, blue;
  logic        hsync, vsync, active, frame_start;

  logic [7:0]  mem [0:65535];
  exp_t        q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          fs_count = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  vga_framebuffer_scanner #(
    .V_ACTIVE(16),
    .V_FP    (2),
    .V_SYNC  (2),
    .V_BP    (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .color_data   (color_data),
    .color_address(color_address),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .hsync        (hsync),
    .vsync        (vsync),
    .active       (active),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  // Asynchronous-read RAM model: data follows the registered address within the clock.
  assign color_data = mem[color_address];

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic string kind_name(int k);
    case (k)
      KRed:    return "red";
      KGrn:    return "green";
      KBlu:    return "blue";
      KHs:     return "hsync";
      KVs:     return "vsync";
      KAct:    return "active";
      KFs:     return "frame_start";
      default: return "color_address";
    endcase
  endfunction

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic expect_at(int c, int k, int v);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic wait_cyc(int c);
    while (cyc != c) @(negedge clk);
  endtask

  // Monitor: pops every expectation due at the current clock index.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_start) fs_count++;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        mon_e = q.pop_front();
        if (mon_e.cyc < cyc) begin
          chk({kind_name(mon_e.kind), "_missed"}, cyc, mon_e.cyc);
        end else begin
          case (mon_e.kind)
            KRed:    chk("red", int'(red), mon_e.val);
            KGrn:    chk("green", int'(green), mon_e.val);
            KBlu:    chk("blue", int'(blue), mon_e.val);
            KHs:     chk("hsync", int'(hsync), mon_e.val);
            KVs:     chk("vsync", int'(vsync), mon_e.val);
            KAct:    chk("active", int'(active), mon_e.val);
            KFs:     chk("frame_start", int'(frame_start), mon_e.val);
            default: chk("color_address", int'(color_address), mon_e.val);
          endcase
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_state(string tag);
    chk({tag, "_red"}, int'(red), 0);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_active"}, int'(active), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_addr"}, int'(color_address), 'h0200);
  endtask

  task automatic push_first_pixels();
    expect_at(1, KAct, 0);  expect_at(1, KFs, 0);
    expect_at(2, KAct, 1);  expect_at(2, KFs, 1);
    expect_at(2, KRed, 'hF); expect_at(2, KGrn, 0); expect_at(2, KBlu, 'hF);
    expect_at(3, KFs, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'hFF;
    mem[16'h0200] = 8'hE3;
    mem[16'h0201] = 8'h1C;
    mem[16'h029F] = 8'h49;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");

    push_first_pixels();
    expect_at(16, KRed, 'hF);   expect_at(16, KGrn, 0);   expect_at(16, KBlu, 'hF);
    expect_at(18, KRed, 0);     expect_at(18, KGrn, 'hF); expect_at(18, KBlu, 0);
    expect_at(32, KRed, 0);     expect_at(32, KGrn, 'hF);
    expect_at(1280, KAct, 1);   expect_at(1280, KRed, 'hF);
    expect_at(1282, KAct, 0);   expect_at(1282, KRed, 0);
    expect_at(1313, KHs, 1);    expect_at(1314, KHs, 0);
    expect_at(1505, KHs, 0);    expect_at(1506, KHs, 1);
    expect_at(2913, KHs, 1);    expect_at(2914, KHs, 0);
    expect_at(12801, KAddr, 'h0250);
    expect_at(14079, KAddr, 'h029F);
    expect_at(14080, KRed, 4);  expect_at(14080, KGrn, 4); expect_at(14080, KBlu, 5);
    expect_at(14081, KAddr, 'h0200);
    expect_at(24201, KAddr, 'h025C);
    expect_at(25602, KAct, 0);  expect_at(25602, KRed, 0); expect_at(25602, KVs, 1);
    expect_at(28801, KVs, 1);   expect_at(28802, KVs, 0);
    expect_at(32001, KVs, 0);   expect_at(32002, KVs, 1);
    expect_at(36801, KFs, 0);
    expect_at(36802, KFs, 1);   expect_at(36802, KAct, 1); expect_at(36802, KRed, 'hF);
    expect_at(36803, KFs, 0);
    // Line 10, pixel 700 of the second frame: inside hsync.
    expect_at(54202, KHs, 0);

    @(negedge clk);
    rst = 1'b0;

    wait_cyc(36810);
    chk("frame_start_count", fs_count, 2);

    wait_cyc(54202);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("midframe_reset");
    chk("pending_before_restart", q.size(), 0);

    push_first_pixels();
    expect_at(1313, KHs, 1);
    expect_at(1314, KHs, 0);
    @(negedge clk);
    rst = 1'b0;

    wait_cyc(1320);
    chk("pending_at_end", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
